// File: rtl/shift_ser_pkg.sv
// Shared types and helpers for the shift_ser_sched scheduler and its arbiter.
// Optional requester-0 priority is selected with SHIFT_SER_SCHED_PRIO0_EN.
package shift_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 4;

    // Ceiling log2; bounded at 31 so the shifted probe never goes negative.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_reg.sv
// Parallel-load, MSB-first shift register: loads on i_load, otherwise shifts left
// every cycle with i_shift entering at bit 0.
module shift_reg #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_shift,
    output logic             o_shift
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = {data_q[WIDTH-2:0], i_shift};
        if (i_load) data_d = i_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) data_q <= '0;
        else         data_q <= data_d;
    end

    assign o_shift = data_q[WIDTH-1];

endmodule

// File: rtl/shift_ser_rr_arb.sv
// Round-robin arbiter: searches upward from the slot after the last winner.
// With SHIFT_SER_SCHED_PRIO0_EN, requester 0 always wins and leaves rr_ptr alone.
module shift_ser_rr_arb
    import shift_ser_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_idx
);

    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic           found;
    logic           prio0_win;
    int             idx;

    always_comb begin
        o_grant_idx = '0;
        found       = 1'b0;
        prio0_win   = 1'b0;
        idx         = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr_q) + 1 + i) % NREQ;
            if (!found && i_req[idx]) begin
                found       = 1'b1;
                o_grant_idx = IDW'(idx);
            end
        end
`ifdef SHIFT_SER_SCHED_PRIO0_EN
        if (i_req[0]) begin
            o_grant_idx = '0;
            prio0_win   = 1'b1;
        end
`endif
        o_grant = found ? ({{(NREQ-1){1'b0}}, 1'b1} << o_grant_idx) : '0;

        rr_ptr_d = rr_ptr_q;
        if (i_advance && found && !prio0_win) rr_ptr_d = o_grant_idx;
    end

    // Reset to the last slot so requester 0 is first in line.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) rr_ptr_q <= IDW'(NREQ - 1);
        else         rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/shift_ser_sched.sv
// Shares one shift_reg among NREQ word requesters, emitting framed MSB-first words
// back to back. Define SHIFT_SER_SCHED_PRIO0_EN to give requester 0 strict priority.
module shift_ser_sched
    import shift_ser_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREQ  = DEF_NREQ,
    localparam int IDW   = clog2(NREQ)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_data,
    output logic [NREQ-1:0]       o_ack,
    output logic                  o_ser_valid,
    output logic                  o_ser_data,
    output logic                  o_ser_first,
    output logic                  o_ser_last,
    output logic [IDW-1:0]        o_ser_src,
    output logic                  o_busy
);

    localparam int              CNTW     = clog2(WIDTH);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0]   src_q, src_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] word;
    logic             any_req;
    logic             at_last;
    logic             load;
    logic             sr_bit;

    assign any_req = |i_req;
    assign at_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    // Gated by reset so no ack can escape while the block is held in reset.
    assign load    = !i_reset && any_req && ((state_q == IDLE) || at_last);

    shift_ser_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_advance   (load),
        .o_grant     (grant),
        .o_grant_idx (grant_idx)
    );

    always_comb begin
        word = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (grant_idx == IDW'(n)) word = i_data[n*WIDTH +: WIDTH];
        end
    end

    shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (load),
        .i_data  (word),
        .i_shift (1'b0),
        .o_shift (sr_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    src_d   = grant_idx;
                end
            end
            SHIFT: begin
                if (load) begin
                    cnt_d = '0;
                    src_d = grant_idx;
                end else if (at_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end

    assign o_ack       = load ? grant : '0;
    assign o_busy      = (state_q == SHIFT);
    assign o_ser_valid = o_busy;
    assign o_ser_data  = o_busy && sr_bit;
    assign o_ser_first = o_busy && (cnt_q == '0);
    assign o_ser_last  = at_last;
    assign o_ser_src   = src_q;

endmodule

// File: tb/tb_shift_ser_sched.sv
// Directed bench for shift_ser_sched (WIDTH=8, NREQ=4); priority expectations
// follow SHIFT_SER_SCHED_PRIO0_EN.
module tb_shift_ser_sched;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic        i_clk   = 1'b0;
    logic        i_reset = 1'b0;
    logic [3:0]  i_req   = '0;
    logic [31:0] i_data  = '0;
    logic [3:0]  o_ack;
    logic        o_ser_valid, o_ser_data, o_ser_first, o_ser_last, o_busy;
    logic [1:0]  o_ser_src;

    int n_cmp = 0;
    int n_bad = 0;

    shift_ser_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_data      (i_data),
        .o_ack       (o_ack),
        .o_ser_valid (o_ser_valid),
        .o_ser_data  (o_ser_data),
        .o_ser_first (o_ser_first),
        .o_ser_last  (o_ser_last),
        .o_ser_src   (o_ser_src),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_req   = '0;
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        #1;
        i_req   = 4'hF;
        i_data  = '1;
        i_reset = 1'b1;
        #1;
        got = {o_ack, o_ser_valid, o_ser_data, o_ser_first, o_ser_last, o_ser_src, o_busy};
        n_cmp++;
        if (got !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_during: got %b want %b", got, 11'b0);
        end
        tick();
        got = {o_ack, o_ser_valid, o_ser_data, o_ser_first, o_ser_last, o_ser_src, o_busy};
        n_cmp++;
        if (got !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_held: got %b want %b", got, 11'b0);
        end
        i_req   = '0;
        i_reset = 1'b0;
        settle();
        got = {o_ack, o_ser_valid, o_ser_data, o_ser_first, o_ser_last, o_ser_src, o_busy};
        n_cmp++;
        if (got !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_after: got %b want %b", got, 11'b0);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        logic [9:0] got, exp;
        w = 8'hA5;
        do_reset();
        i_data[23:16] = w;
        i_req = 4'b0100;
        settle();
        n_cmp++;
        if ({o_ack, o_ser_valid} !== 5'b0100_0) begin
            n_bad++;
            $display("FAIL single_ack: got %b want %b", {o_ack, o_ser_valid}, 5'b0100_0);
        end
        tick();
        i_req = '0;
        for (int k = 0; k < 8; k++) begin
            settle();
            got = {o_ser_valid, o_ser_data, o_ser_first, o_ser_last, o_ser_src, o_ack};
            exp = {1'b1, w[7-k], (k == 0), (k == 7), 2'd2, 4'b0000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL single_bit%0d: got %b want %b", k, got, exp);
            end
            tick();
        end
        settle();
        n_cmp++;
        if ({o_ser_valid, o_busy, o_ack} !== 6'b0) begin
            n_bad++;
            $display("FAIL single_idle: got %b want %b", {o_ser_valid, o_busy, o_ack}, 6'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [2];
        logic [9:0] got, exp;
        logic [3:0] exp_ack;
        words[0] = 8'hFF;
        words[1] = 8'h00;
        do_reset();
        i_data[7:0]  = words[0];
        i_data[15:8] = words[1];
        i_req = 4'b0011;
        settle();
        n_cmp++;
        if (o_ack !== 4'b0001) begin
            n_bad++;
            $display("FAIL b2b_ack0: got %b want %b", o_ack, 4'b0001);
        end
        tick();
        i_req = 4'b0010;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 8; k++) begin
                settle();
                exp_ack = (w == 0 && k == 7) ? 4'b0010 : 4'b0000;
                got = {o_ser_valid, o_ser_data, o_ser_first, o_ser_last, o_ser_src, o_ack};
                exp = {1'b1, words[w][7-k], (k == 0), (k == 7), 2'(w), exp_ack};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL b2b_w%0d_bit%0d: got %b want %b", w, k, got, exp);
                end
                tick();
                if (w == 0 && k == 7) i_req = '0;
            end
        end
        settle();
        n_cmp++;
        if ({o_ser_valid, o_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_idle: got %b want %b", {o_ser_valid, o_busy}, 2'b00);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] fw [4];
        int         ord [5];
        logic [9:0] got, exp;
        logic [3:0] exp_ack;
        fw[0] = 8'h3C; fw[1] = 8'hA6; fw[2] = 8'h5A; fw[3] = 8'h96;
        ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3; ord[4] = 0;
        do_reset();
        i_data = {fw[3], fw[2], fw[1], fw[0]};
        i_req  = 4'hF;
        settle();
        n_cmp++;
        if (o_ack !== 4'b0001) begin
            n_bad++;
            $display("FAIL fair_ack0: got %b want %b", o_ack, 4'b0001);
        end
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < 8; k++) begin
                tick();
                settle();
                exp_ack = '0;
                if (k == 7 && w < 4) exp_ack = 4'b0001 << ord[w+1];
                got = {o_ser_valid, o_ser_data, o_ser_first, o_ser_last, o_ser_src, o_ack};
                exp = {1'b1, fw[ord[w]][7-k], (k == 0), (k == 7), 2'(ord[w]), exp_ack};
                if (k == 7 && w == 4) exp[3:0] = o_ack;
                if (k == 0 || k == 7) begin
                    n_cmp++;
                    if (got !== exp) begin
                        n_bad++;
                        $display("FAIL fair_w%0d_bit%0d: got %b want %b", w, k, got, exp);
                    end
                end
            end
        end
        i_req = '0;
    endtask

    task automatic test_priority();
        int         ord [4];
        logic [3:0] exp_ack;
        logic [2:0] got, exp;
`ifdef SHIFT_SER_SCHED_PRIO0_EN
        ord[0] = 0; ord[1] = 0; ord[2] = 0; ord[3] = 0;
`else
        ord[0] = 0; ord[1] = 3; ord[2] = 0; ord[3] = 3;
`endif
        do_reset();
        i_data[7:0]   = 8'hF0;
        i_data[31:24] = 8'h0F;
        i_req = 4'b1001;
        settle();
        n_cmp++;
        if (o_ack !== 4'b0001) begin
            n_bad++;
            $display("FAIL prio_ack0: got %b want %b", o_ack, 4'b0001);
        end
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 8; k++) begin
                tick();
                settle();
                if (k == 0) begin
                    got = {o_ser_first, o_ser_src};
                    exp = {1'b1, 2'(ord[w])};
                    n_cmp++;
                    if (got !== exp) begin
                        n_bad++;
                        $display("FAIL prio_src_w%0d: got %b want %b", w, got, exp);
                    end
                end
                if (k == 7 && w < 3) begin
                    exp_ack = 4'b0001 << ord[w+1];
                    n_cmp++;
                    if (o_ack !== exp_ack) begin
                        n_bad++;
                        $display("FAIL prio_ack_w%0d: got %b want %b", w + 1, o_ack, exp_ack);
                    end
                end
            end
        end
        i_req = '0;
    endtask

    task automatic test_reset_mid_word();
        logic [7:0]  w;
        logic [10:0] got;
        w = 8'hC3;
        do_reset();
        i_data[7:0] = w;
        i_req = 4'b0001;
        settle();
        n_cmp++;
        if (o_ack !== 4'b0001) begin
            n_bad++;
            $display("FAIL midrst_ack: got %b want %b", o_ack, 4'b0001);
        end
        tick();
        i_req = '0;
        for (int k = 0; k < 4; k++) begin
            settle();
            n_cmp++;
            if ({o_ser_valid, o_ser_data} !== {1'b1, w[7-k]}) begin
                n_bad++;
                $display("FAIL midrst_bit%0d: got %b want %b", k, {o_ser_valid, o_ser_data}, {1'b1, w[7-k]});
            end
            if (k < 3) tick();
        end
        i_reset = 1'b1;
        #1;
        got = {o_ack, o_ser_valid, o_ser_data, o_ser_first, o_ser_last, o_ser_src, o_busy};
        n_cmp++;
        if (got !== 11'b0) begin
            n_bad++;
            $display("FAIL midrst_drop: got %b want %b", got, 11'b0);
        end
        tick();
        tick();
        i_reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_cmp++;
            if ({o_busy, o_ser_valid, o_ack} !== 6'b0) begin
                n_bad++;
                $display("FAIL midrst_idle%0d: got %b want %b", c, {o_busy, o_ser_valid, o_ack}, 6'b0);
            end
            tick();
        end
    endtask

    task automatic test_withdrawn();
        logic [7:0] w;
        logic [7:0] got, exp;
        w = 8'h5A;
        do_reset();
        i_data[31:24] = w;
        i_req = 4'b1000;
        settle();
        n_cmp++;
        if (o_ack !== 4'b1000) begin
            n_bad++;
            $display("FAIL wd_ack: got %b want %b", o_ack, 4'b1000);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            i_req = (k == 3) ? 4'b0010 : 4'b0000;
            settle();
            got = {o_ser_valid, o_ser_data, o_ser_src, o_ack};
            exp = {1'b1, w[7-k], 2'd3, 4'b0000};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL wd_bit%0d: got %b want %b", k, got, exp);
            end
            tick();
        end
        i_req = '0;
        for (int c = 0; c < 2; c++) begin
            settle();
            n_cmp++;
            if ({o_busy, o_ser_valid, o_ack} !== 6'b0) begin
                n_bad++;
                $display("FAIL wd_idle%0d: got %b want %b", c, {o_busy, o_ser_valid, o_ack}, 6'b0);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_fairness();
        test_priority();
        test_reset_mid_word();
        test_withdrawn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
